// File: rtl/halflife_sequencer.sv
// Half-life timer sequencer: loads a population and period on start, then halves
// the population every period cycles until it reaches zero.
module halflife_sequencer #(
  parameter int n  = 8,
  parameter int PW = 8,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [n-1:0]  init_val,
  input  logic [PW-1:0] period,
  output logic [n-1:0]  value,
  output logic [HW-1:0] halvings,
  output logic          half_pulse,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [n-1:0]  value_q, value_d;
  logic [HW-1:0] halvings_q, halvings_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [PW-1:0] period_q, period_d;
  logic          half_pulse_q, half_pulse_d;
  logic [PW-1:0] period_eff;

  // A zero period would never expire, so it behaves as a one-cycle period.
  assign period_eff = (period == '0) ? PW'(1) : period;

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    halvings_d   = halvings_q;
    timer_d      = timer_q;
    period_d     = period_q;
    half_pulse_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q == PW'(1)) begin
          value_d      = value_q >> 1;
          halvings_d   = halvings_q + 1'b1;
          timer_d      = period_q;
          half_pulse_d = 1'b1;
          if ((value_q >> 1) == '0) state_d = S_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a start; abort wins over a simultaneous start.
        if (start && !abort) begin
          period_d   = period_eff;
          timer_d    = period_eff;
          value_d    = init_val;
          halvings_d = '0;
          state_d    = (init_val == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      value_q      <= '0;
      halvings_q   <= '0;
      timer_q      <= '0;
      period_q     <= '0;
      half_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      halvings_q   <= halvings_d;
      timer_q      <= timer_d;
      period_q     <= period_d;
      half_pulse_q <= half_pulse_d;
    end
  end

  assign value      = value_q;
  assign halvings   = halvings_q;
  assign half_pulse = half_pulse_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule
